bit_counter_sched: RTL

Sequencing controller and two-requester scheduler for the bit-counter datapath. It accepts popcount jobs from two independent requesters and arbitrates between them round-robin. It drives the datapath control strobes (init_A, init_res, shiftr_A, incr_res) and the load operand until the shifted operand reaches zero. It then presents the count to the winning requester under a valid/ack handshake. It sits between the user-side request logic and one bit_counter datapath instance.

---
 rtl/bit_counter_pkg.sv | 21 ++
 rtl/bit_counter_sched_if.sv | 27 ++
 rtl/bit_counter.sv | 35 +++
 rtl/bit_counter_sched_rr_arbiter2.sv | 19 +
 rtl/bit_counter_sched.sv | 96 +++++++++
 5 files changed

// File: rtl/bit_counter_pkg.sv
// Shared types and defaults for the bit-counter scheduler slice.
package bit_counter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int N_REQ      = 2;
    localparam int DATA_W_DEF = 8;
    localparam int RES_W_DEF  = 4;

    function automatic logic [N_REQ-1:0] onehot(input logic id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bit_counter_sched_if.sv
// Requester-side job bus: level requests, operands, result valid/ack handshake.
interface bit_counter_sched_if
    import bit_counter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RES_W  = RES_W_DEF
);
    logic [N_REQ-1:0]  req;
    logic [DATA_W-1:0] A0;
    logic [DATA_W-1:0] A1;
    logic              ack;
    logic [N_REQ-1:0]  grant;
    logic              busy;
    logic              done_valid;
    logic              done_id;
    logic [RES_W-1:0]  count;

    modport master (
        output req, A0, A1, ack,
        input  grant, busy, done_valid, done_id, count
    );

    modport slave (
        input  req, A0, A1, ack,
        output grant, busy, done_valid, done_id, count
    );
endinterface

// File: rtl/bit_counter.sv
// Popcount datapath: loadable right-shift operand register plus running count.
// Latency: one cycle per strobe; backpressure: holds whenever no strobe is set.
module bit_counter
#(
    parameter int DATA_W = 8,
    parameter int RES_W  = 4
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              init_A,
    input  logic              init_res,
    input  logic              shiftr_A,
    input  logic              incr_res,
    input  logic [DATA_W-1:0] A_load,
    output logic [DATA_W-1:0] A_curr,
    output logic [RES_W-1:0]  result
);
    always_ff @(posedge clk) begin
        if (reset) begin
            A_curr <= '0;
            result <= '0;
        end else begin
            if (init_A)
                A_curr <= A_load;
            else if (shiftr_A)
                A_curr <= A_curr >> 1;

            if (init_res)
                result <= '0;
            else if (incr_res)
                result <= result + 1'b1;
        end
    end
endmodule

// File: rtl/bit_counter_sched_rr_arbiter2.sv
// Two-way round-robin pick, favouring the requester that was not served last.
// Latency: combinational; backpressure: none, pointer is held by the caller.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);
    always_comb begin
        winner = 1'b0;
        any    = |req;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end
endmodule

// File: rtl/bit_counter_sched.sv
// Arbitrates two requesters and sequences the popcount datapath until the operand drains.
// Latency: k+2 cycles from init to done_valid; backpressure: result held until ack.
module bit_counter_sched
    import bit_counter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RES_W  = RES_W_DEF
)
(
    input  logic              clk,
    input  logic              reset,
    bit_counter_sched_if.slave io,
    input  logic [DATA_W-1:0] A_curr,
    input  logic [RES_W-1:0]  result,
    output logic [DATA_W-1:0] A_load,
    output logic              init_A,
    output logic              init_res,
    output logic              shiftr_A,
    output logic              incr_res
);
    state_t state, nstate;
    logic   owner;
    logic   last;
    logic   winner;
    logic   any;

    rr_arbiter2 u_arb (
        .req    (io.req),
        .last   (last),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= nstate;
            if (state == S_IDLE && any)
                owner <= winner;
            if (state == S_DONE && io.ack)
                last <= owner;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (any) nstate = S_COUNT;
            S_COUNT: if (A_curr == '0) nstate = S_DONE;
            S_DONE:  if (io.ack) nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // Idle strobes and A_load are Mealy on req so the init lands in the request cycle.
    always_comb begin
        init_A        = 1'b0;
        init_res      = 1'b0;
        shiftr_A      = 1'b0;
        incr_res      = 1'b0;
        A_load        = '0;
        io.grant      = '0;
        io.busy       = 1'b0;
        io.done_valid = 1'b0;
        io.done_id    = 1'b0;
        io.count      = '0;
        case (state)
            S_IDLE: begin
                if (any) begin
                    init_A   = 1'b1;
                    init_res = 1'b1;
                    A_load   = winner ? io.A1 : io.A0;
                end
            end
            S_COUNT: begin
                io.grant = onehot(owner);
                io.busy  = 1'b1;
                if (A_curr != '0) begin
                    shiftr_A = 1'b1;
                    incr_res = A_curr[0];
                end
            end
            S_DONE: begin
                io.grant      = onehot(owner);
                io.busy       = 1'b1;
                io.done_valid = 1'b1;
                io.done_id    = owner;
                io.count      = result;
            end
            default: ;
        endcase
    end
endmodule
